// File: rtl/axis_keep_width_converter.sv
`default_nettype none
// ============================================================================
// Module   : axis_keep_width_converter
// Brief    : Byte-granular AXI-Stream width converter (pack / unpack / wire)
//            with tkeep support and one narrow beat per cycle throughput.
// Revision : 1.0 - initial release
// ============================================================================
module axis_keep_width_converter #(
    parameter int AXIS_I_BYTES = 1,
    parameter int AXIS_O_BYTES = 1
) (
    input  logic                      clk,
    input  logic                      areset,
    output logic                      axis_i_tready,
    input  logic                      axis_i_tvalid,
    input  logic                      axis_i_tlast,
    input  logic [AXIS_I_BYTES-1:0]   axis_i_tkeep,
    input  logic [AXIS_I_BYTES*8-1:0] axis_i_tdata,
    input  logic                      axis_o_tready,
    output logic                      axis_o_tvalid,
    output logic                      axis_o_tlast,
    output logic [AXIS_O_BYTES-1:0]   axis_o_tkeep,
    output logic [AXIS_O_BYTES*8-1:0] axis_o_tdata
);

    localparam int c_NARROW = (AXIS_I_BYTES < AXIS_O_BYTES) ? AXIS_I_BYTES : AXIS_O_BYTES;
    localparam int c_WIDE   = (AXIS_I_BYTES < AXIS_O_BYTES) ? AXIS_O_BYTES : AXIS_I_BYTES;
    localparam int c_RATIO  = c_WIDE / c_NARROW;
    localparam int c_CTR_W  = (c_RATIO > 1) ? $clog2(c_RATIO) : 1;
    localparam logic [c_CTR_W-1:0] c_CTR_MAX = c_CTR_W'(c_RATIO - 1);
    localparam logic [c_CTR_W-1:0] c_CTR_ONE = c_CTR_W'(1);

    generate
        if ((c_WIDE % c_NARROW) != 0) begin : g_bad_ratio
            $error("axis_keep_width_converter: wide width must be a multiple of narrow width");
        end

        if (AXIS_I_BYTES == AXIS_O_BYTES) begin : g_passthru
            // Clock and reset are intentionally unused in the equal-width case.
            logic w_unused;
            assign w_unused      = clk ^ areset;
            assign axis_i_tready = axis_o_tready;
            assign axis_o_tvalid = axis_i_tvalid;
            assign axis_o_tlast  = axis_i_tlast;
            assign axis_o_tkeep  = axis_i_tkeep;
            assign axis_o_tdata  = axis_i_tdata;

        end else if (AXIS_I_BYTES < AXIS_O_BYTES) begin : g_pack
            localparam int c_LB = AXIS_I_BYTES;

            logic [c_CTR_W-1:0]        r_ctr;
            logic [AXIS_O_BYTES*8-1:0] r_data;
            logic [AXIS_O_BYTES-1:0]   r_keep;
            logic                      r_last;
            logic                      r_valid;
            logic [AXIS_O_BYTES*8-1:0] w_data_nxt;
            logic [AXIS_O_BYTES-1:0]   w_keep_nxt;
            logic                      w_in_fire;
            logic                      w_out_fire;
            logic                      w_word_done;

            assign w_out_fire    = r_valid && axis_o_tready;
            assign axis_i_tready = !areset && (!r_valid || axis_o_tready);
            assign w_in_fire     = axis_i_tvalid && axis_i_tready;
            assign w_word_done   = w_in_fire && (axis_i_tlast || (r_ctr == c_CTR_MAX));

            // Lane 0 starts a fresh word, so every other lane is cleared with it.
            always_comb begin
                w_data_nxt = (r_ctr == '0) ? '0 : r_data;
                w_keep_nxt = (r_ctr == '0) ? '0 : r_keep;
                for (int n = 0; n < c_RATIO; n++) begin
                    if (r_ctr == c_CTR_W'(n)) begin
                        w_data_nxt[n*c_LB*8 +: c_LB*8] = axis_i_tdata;
                        w_keep_nxt[n*c_LB +: c_LB]     = axis_i_tkeep;
                    end
                end
            end

            always_ff @(posedge clk or posedge areset) begin
                if (areset) begin
                    r_ctr   <= '0;
                    r_data  <= '0;
                    r_keep  <= '0;
                    r_last  <= 1'b0;
                    r_valid <= 1'b0;
                end else begin
                    if (w_in_fire) begin
                        r_data <= w_data_nxt;
                        r_keep <= w_keep_nxt;
                        r_last <= axis_i_tlast;
                        r_ctr  <= w_word_done ? '0 : (r_ctr + c_CTR_ONE);
                    end
                    if (w_word_done) begin
                        r_valid <= 1'b1;
                    end else if (w_out_fire) begin
                        r_valid <= 1'b0;
                    end
                end
            end

            assign axis_o_tvalid = r_valid;
            assign axis_o_tlast  = r_last;
            assign axis_o_tkeep  = r_keep;
            assign axis_o_tdata  = r_data;

        end else begin : g_unpack
            localparam int c_LB = AXIS_O_BYTES;

            logic [c_CTR_W-1:0]             r_ctr;
            logic [AXIS_I_BYTES*8-1:0]      r_data;
            logic [AXIS_I_BYTES-1:0]        r_keep;
            logic                           r_last;
            logic                           r_valid;
            logic [AXIS_I_BYTES+c_LB-1:0]   w_keep_pad;
            logic [c_LB*8-1:0]              w_lane_data;
            logic [c_LB-1:0]                w_lane_keep;
            logic                           w_next_used;
            logic                           w_last_chunk;
            logic                           w_in_fire;
            logic                           w_out_fire;

            // An always-empty pseudo-lane above the top lane makes the top lane
            // terminate the word without a separate counter compare.
            assign w_keep_pad = {{c_LB{1'b0}}, r_keep};

            always_comb begin
                w_lane_data = '0;
                w_lane_keep = '0;
                w_next_used = 1'b0;
                for (int n = 0; n < c_RATIO; n++) begin
                    if (r_ctr == c_CTR_W'(n)) begin
                        w_lane_data = r_data[n*c_LB*8 +: c_LB*8];
                        w_lane_keep = r_keep[n*c_LB +: c_LB];
                        w_next_used = |w_keep_pad[(n+1)*c_LB +: c_LB];
                    end
                end
            end

            assign w_last_chunk  = !w_next_used;
            assign w_out_fire    = r_valid && axis_o_tready;
            assign axis_i_tready = !areset && (!r_valid || (axis_o_tready && w_last_chunk));
            assign w_in_fire     = axis_i_tvalid && axis_i_tready;

            always_ff @(posedge clk or posedge areset) begin
                if (areset) begin
                    r_ctr   <= '0;
                    r_data  <= '0;
                    r_keep  <= '0;
                    r_last  <= 1'b0;
                    r_valid <= 1'b0;
                end else if (w_in_fire) begin
                    r_data  <= axis_i_tdata;
                    r_keep  <= axis_i_tkeep;
                    r_last  <= axis_i_tlast;
                    r_valid <= 1'b1;
                    r_ctr   <= '0;
                end else if (w_out_fire) begin
                    if (w_last_chunk) begin
                        r_valid <= 1'b0;
                    end else begin
                        r_ctr <= r_ctr + c_CTR_ONE;
                    end
                end
            end

            assign axis_o_tvalid = r_valid;
            assign axis_o_tlast  = r_last && w_last_chunk;
            assign axis_o_tkeep  = w_lane_keep;
            assign axis_o_tdata  = w_lane_data;
        end
    endgenerate

endmodule
`default_nettype wire
